// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for pipe_stage_buf: upstream (in_*) and downstream (out_*) sides.
// A beat moves on a rising edge where valid & ready are both 1; once valid is raised, the producer
// holds valid and data stable until that edge. ready may rise and fall freely. data is don't-care while valid=0.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 256
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register: NUM_STAGES valid/ready stages fed through a registered skid entry,
// with flush, a saturating stall counter and an occupancy count.
module pipe_stage_buf #(
  parameter int  DATA_W         = 256,
  parameter int  NUM_STAGES     = 1,
  parameter bit  CLEAR_ON_FLUSH = 1'b1,
  parameter int  CNT_W          = 16,
  localparam int OCC_W          = $clog2(NUM_STAGES + 2)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               flush,
  pipe_stage_buf_if.slave    bus,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [OCC_W-1:0]   occupancy
);

  logic [NUM_STAGES-1:0] v_q, v_d;
  logic [DATA_W-1:0]     data_q [NUM_STAGES];
  logic [DATA_W-1:0]     data_d [NUM_STAGES];
  logic                  skid_v_q, skid_v_d;
  logic [DATA_W-1:0]     skid_data_q, skid_data_d;
  logic                  in_ready_q, in_ready_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [OCC_W-1:0]      occ_q, occ_d;

  logic [NUM_STAGES:0]   adv;
  logic                  chain;
  logic                  up_xfer;
  logic                  src_v;
  logic [DATA_W-1:0]     src_data;

  always_comb begin
    // Advance terms ripple back from the consumer; a hole anywhere lets everything behind it move.
    chain = bus.out_ready;
    adv   = '0;
    adv[NUM_STAGES] = chain;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      chain  = !v_q[i] | chain;
      adv[i] = chain;
    end

    up_xfer  = bus.in_valid & in_ready_q;
    src_v    = skid_v_q | up_xfer;
    src_data = skid_v_q ? skid_data_q : bus.in_data;

    v_d    = v_q;
    data_d = data_q;
    if (adv[0]) begin
      v_d[0]    = src_v;
      data_d[0] = src_data;
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (adv[i]) begin
        v_d[i]    = v_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end

    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    if (skid_v_q && adv[0]) begin
      skid_v_d = 1'b0;
    end else if (up_xfer && !adv[0]) begin
      skid_v_d    = 1'b1;
      skid_data_d = bus.in_data;
    end

    // Flush overrides every transfer computed above, including a beat offered this cycle.
    if (flush) begin
      v_d      = '0;
      skid_v_d = 1'b0;
      if (CLEAR_ON_FLUSH) begin
        skid_data_d = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
          data_d[i] = '0;
        end
      end
    end

    in_ready_d = !skid_v_d;

    stall_cnt_d = stall_cnt_q;
    if (v_q[NUM_STAGES-1] && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    occ_d = OCC_W'(skid_v_d);
    for (int i = 0; i < NUM_STAGES; i++) begin
      occ_d = occ_d + OCC_W'(v_d[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      v_q         <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
      occ_q       <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      v_q         <= v_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
      occ_q       <= occ_d;
      for (int i = 0; i < NUM_STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = v_q[NUM_STAGES-1];
  assign bus.out_data  = data_q[NUM_STAGES-1];
  assign stall_cnt     = stall_cnt_q;
  assign occupancy     = occ_q;

endmodule
